// File: rtl/dkong_i2s_tx.sv
// I2S transmitter for the Donkey Kong mono mixer: 48 kHz frames of 64 bit slots,
// with one 16-bit sample duplicated into the left and right words.
module dkong_i2s_tx #(
  parameter int unsigned W_CLK_24576M_RATE = 24576000,
  parameter int unsigned SAMPLE_RATE       = 48000
) (
  input  logic        W_CLK_24576M,
  input  logic        W_RESETn,
  input  logic [15:0] I_SAMPLE,
  input  logic        I_SAMPLE_EN,
  input  logic        I_MUTE,
  output logic        O_MCLK,
  output logic        O_BCLK,
  output logic        O_LRCK,
  output logic        O_SDATA,
  output logic        O_SAMPLE_REQ,
  output logic        O_UNDERRUN
);

  localparam int unsigned CLKS_PER_FRAME = 512;
  localparam int unsigned POS_W          = 9;
  localparam int unsigned SLOT_W         = 6;
  localparam int unsigned WORD_W         = 16;

  // The position counter and slot map only work for exactly 512 clocks per frame.
  if (W_CLK_24576M_RATE / SAMPLE_RATE != CLKS_PER_FRAME ||
      W_CLK_24576M_RATE % SAMPLE_RATE != 0) begin : g_bad_ratio
    $error("dkong_i2s_tx: W_CLK_24576M_RATE/SAMPLE_RATE must equal 512");
  end

  logic [POS_W-1:0]  pos;
  logic [WORD_W-1:0] pend;
  logic [WORD_W-1:0] frame_word;
  logic              fresh;
  logic              stale;
  logic              boundary_c;
  logic [SLOT_W-1:0] slot_c;

  logic mclk_d, bclk_d, lrck_d, sdata_d, req_d, underrun_d;

  assign boundary_c = (pos == POS_W'(CLKS_PER_FRAME - 1));
  assign slot_c     = pos[8:3];

  // Output values for the current position; registered below so the pins
  // follow the counter by one clock and never see the inputs directly.
  always_comb begin
    mclk_d     = ~pos[0];
    bclk_d     = pos[2];
    lrck_d     = (slot_c >= SLOT_W'(31)) && (slot_c <= SLOT_W'(62));
    sdata_d    = 1'b0;
    req_d      = (pos == '0);
    underrun_d = (pos == '0) && stale;
    // Slots 0..15 and 32..47 carry the word MSB first; slot[4] marks padding.
    if (!slot_c[4]) begin
      sdata_d = frame_word[4'd15 - slot_c[3:0]];
    end
  end

  // Frame position and sample hand-off state.
  always_ff @(posedge W_CLK_24576M or negedge W_RESETn) begin
    if (!W_RESETn) begin
      pos        <= '0;
      pend       <= '0;
      frame_word <= '0;
      fresh      <= 1'b0;
      stale      <= 1'b0;
    end else begin
      pos <= pos + POS_W'(1);
      if (boundary_c) begin
        frame_word <= I_MUTE ? '0 : pend;
        stale      <= ~fresh;
      end
      // A strobe on the boundary clock still lands in pend and counts as fresh.
      if (I_SAMPLE_EN) begin
        pend  <= I_SAMPLE;
        fresh <= 1'b1;
      end else if (boundary_c) begin
        fresh <= 1'b0;
      end
    end
  end

  always_ff @(posedge W_CLK_24576M or negedge W_RESETn) begin
    if (!W_RESETn) begin
      O_MCLK       <= 1'b0;
      O_BCLK       <= 1'b0;
      O_LRCK       <= 1'b0;
      O_SDATA      <= 1'b0;
      O_SAMPLE_REQ <= 1'b0;
      O_UNDERRUN   <= 1'b0;
    end else begin
      O_MCLK       <= mclk_d;
      O_BCLK       <= bclk_d;
      O_LRCK       <= lrck_d;
      O_SDATA      <= sdata_d;
      O_SAMPLE_REQ <= req_d;
      O_UNDERRUN   <= underrun_d;
    end
  end

endmodule

// File: tb/tb_dkong_i2s_tx.sv
// Scoreboard bench for dkong_i2s_tx: a frame model queues expected words,
// a monitor decodes each transmitted frame and compares.
module tb_dkong_i2s_tx;

  logic        W_CLK_24576M = 1'b0;
  logic        W_RESETn     = 1'b0;
  logic [15:0] I_SAMPLE     = '0;
  logic        I_SAMPLE_EN  = 1'b0;
  logic        I_MUTE       = 1'b0;
  logic        O_MCLK, O_BCLK, O_LRCK, O_SDATA, O_SAMPLE_REQ, O_UNDERRUN;

  dkong_i2s_tx dut (
    .W_CLK_24576M (W_CLK_24576M),
    .W_RESETn     (W_RESETn),
    .I_SAMPLE     (I_SAMPLE),
    .I_SAMPLE_EN  (I_SAMPLE_EN),
    .I_MUTE       (I_MUTE),
    .O_MCLK       (O_MCLK),
    .O_BCLK       (O_BCLK),
    .O_LRCK       (O_LRCK),
    .O_SDATA      (O_SDATA),
    .O_SAMPLE_REQ (O_SAMPLE_REQ),
    .O_UNDERRUN   (O_UNDERRUN)
  );

  always #5 W_CLK_24576M = ~W_CLK_24576M;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  typedef struct packed {
    logic [15:0] word;
    logic        under;
  } exp_t;

  exp_t       exp_q[$];
  logic [8:0] m_pos   = '0;
  logic [15:0] m_p    = '0;
  logic       m_fresh = 1'b0;

  // Frame model: decides each frame's word and underrun at the boundary clock.
  initial begin
    forever begin
      @(posedge W_CLK_24576M or negedge W_RESETn);
      if (!W_RESETn) begin
        m_pos   = '0;
        m_p     = '0;
        m_fresh = 1'b0;
        exp_q.delete();
        exp_q.push_back('{word: 16'h0000, under: 1'b0});
      end else begin
        if (m_pos == 9'd511) begin
          exp_q.push_back('{word: (I_MUTE ? 16'h0000 : m_p), under: ~m_fresh});
          m_fresh = 1'b0;
        end
        if (I_SAMPLE_EN) begin
          m_p     = I_SAMPLE;
          m_fresh = 1'b1;
        end
        m_pos = m_pos + 9'd1;
      end
    end
  end

  logic [8:0]  opos;
  logic [5:0]  oslot;
  logic [15:0] lw, rw;
  logic        ur, sd0;
  exp_t        cur;
  bit          act = 0;
  int          cyc = 0;
  int          errs = 0;
  int          frames = 0;

  // Monitor: aligns on O_SAMPLE_REQ, checks pin timing and decodes both words.
  initial begin
    forever begin
      @(negedge W_CLK_24576M);
      if (!W_RESETn) begin
        act = 0;
        continue;
      end
      if (O_SAMPLE_REQ) begin
        if (act) check("req_period", cyc, 512);
        if (exp_q.size() == 0) begin
          check("exp_q_empty", 1, 0);
          act = 0;
        end else begin
          cur = exp_q.pop_front();
          act = 1;
        end
        opos = '0; cyc = 0; lw = '0; rw = '0; errs = 0; ur = O_UNDERRUN;
      end else begin
        opos = opos + 9'd1;
      end
      cyc++;
      if (act) begin
        oslot = opos[8:3];
        if (O_MCLK !== ~opos[0]) errs++;
        if (O_BCLK !== opos[2]) errs++;
        if (O_LRCK !== ((oslot >= 6'd31) && (oslot <= 6'd62))) errs++;
        if (opos != 0 && (O_SAMPLE_REQ || O_UNDERRUN)) errs++;
        if (opos[2:0] == 3'd0) begin
          sd0 = O_SDATA;
          if (!oslot[4]) begin
            if (oslot[5]) rw = {rw[14:0], O_SDATA};
            else          lw = {lw[14:0], O_SDATA};
          end else if (O_SDATA !== 1'b0) begin
            errs++;
          end
        end else if (O_SDATA !== sd0) begin
          errs++;
        end
        if (opos == 9'd511) begin
          frames++;
          check("left_word", lw, cur.word);
          check("right_word", rw, cur.word);
          check("underrun", ur, cur.under);
          check("frame_timing", errs, 0);
        end
      end
    end
  end

  task automatic wait_pos(input int p);
    int n = 0;
    do begin
      @(posedge W_CLK_24576M);
      #1;
      n++;
    end while (m_pos != 9'(p) && n < 1100);
    if (m_pos != 9'(p)) check("wait_timeout", m_pos, p);
  endtask

  task automatic strobe_at(input int p, input logic [15:0] v);
    wait_pos(p);
    I_SAMPLE    = v;
    I_SAMPLE_EN = 1'b1;
    @(posedge W_CLK_24576M);
    #1;
    I_SAMPLE_EN = 1'b0;
  endtask

  initial begin
    repeat (3) @(posedge W_CLK_24576M);
    #1;
    check("reset_outputs", {O_MCLK, O_BCLK, O_LRCK, O_SDATA, O_SAMPLE_REQ, O_UNDERRUN}, 0);
    @(negedge W_CLK_24576M);
    W_RESETn = 1'b1;
    @(posedge W_CLK_24576M);
    #1;
    check("first_req", O_SAMPLE_REQ, 1);
    check("first_underrun", O_UNDERRUN, 0);

    strobe_at(100, 16'h8001);
    strobe_at(50, 16'h1234);
    repeat (3) wait_pos(0);

    strobe_at(10, 16'h7FFF);
    wait_pos(505);
    I_MUTE = 1'b1;
    wait_pos(0);
    I_MUTE = 1'b0;
    wait_pos(0);

    wait_pos(20);
    I_MUTE = 1'b1;
    strobe_at(200, 16'h5555);
    wait_pos(400);
    I_MUTE = 1'b0;
    strobe_at(511, 16'hAAAA);

    wait_pos(0);
    strobe_at(100, 16'h1111);
    strobe_at(300, 16'hFEDC);

    wait_pos(300);
    #2;
    W_RESETn = 1'b0;
    #1;
    check("async_reset_outputs", {O_MCLK, O_BCLK, O_LRCK, O_SDATA, O_SAMPLE_REQ, O_UNDERRUN}, 0);
    repeat (2) @(posedge W_CLK_24576M);
    @(negedge W_CLK_24576M);
    W_RESETn = 1'b1;
    @(posedge W_CLK_24576M);
    #1;
    check("req_after_reset", O_SAMPLE_REQ, 1);
    check("underrun_after_reset", O_UNDERRUN, 0);

    repeat (2) wait_pos(0);
    repeat (2) @(posedge W_CLK_24576M);
    #1;
    check("frames_checked", frames, 11);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dkong_i2s_tx.md
DKONG_I2S_TX -- requirements
Module: dkong_i2s_tx

Interface
REQ-001 Parameter W_CLK_24576M_RATE, default 24576000, system clock rate in Hz.
REQ-002 Parameter SAMPLE_RATE, default 48000, output frame rate in Hz; W_CLK_24576M_RATE/SAMPLE_RATE SHALL equal 512, and elaboration SHALL fail otherwise.
REQ-003 W_CLK_24576M  input  1  sole clock; all logic is rising-edge.
REQ-004 W_RESETn  input  1  reset, asynchronous assert, active-low.
REQ-005 I_SAMPLE  input  16  signed two's-complement mono mixer sample.
REQ-006 I_SAMPLE_EN  input  1  one-clock strobe qualifying I_SAMPLE.
REQ-007 I_MUTE  input  1  forces transmitted data to zero.
REQ-008 O_MCLK  output  1  master clock, clk/2 (12.288 MHz, 256 fs).
REQ-009 O_BCLK  output  1  bit clock, clk/8 (3.072 MHz, 64 fs).
REQ-010 O_LRCK  output  1  word select: 0 = left, 1 = right.
REQ-011 O_SDATA  output  1  I2S serial data, MSB first.
REQ-012 O_SAMPLE_REQ  output  1  one-clock pulse per frame requesting the next sample.
REQ-013 O_UNDERRUN  output  1  one-clock pulse when a frame repeats a stale sample.

Function
REQ-014 A 9-bit position counter pos SHALL increment every clock and wrap from 511 to 0.
REQ-015 Slot index s = pos[8:3], range 0..63; each slot SHALL last 8 clocks.
REQ-016 All outputs SHALL be registers whose values during position p depend only on p and state latched at frame boundaries, with no combinational path from inputs.
REQ-017 O_MCLK SHALL equal pos[0] inverted, so it toggles every clock.
REQ-018 O_BCLK SHALL be low for pos[2:0] = 0..3 and high for 4..7.
REQ-019 O_SDATA and O_LRCK SHALL change only at pos[2:0] = 0, which is the BCLK falling edge.
REQ-020 O_LRCK SHALL be 1 for slots 31..62 and 0 for slots 63 and 0..30, so it leads each word by one BCLK.
REQ-021 O_SDATA content by slot:
- slots 0..15: left word bits 15..0;
- slots 32..47: right word bits 15..0;
- all other slots: 0.
REQ-022 Left and right words SHALL both equal the frame word F.
REQ-023 A pending register P and a fresh flag SHALL capture I_SAMPLE and set fresh on any clock where I_SAMPLE_EN=1.
REQ-024 At pos=511 (frame boundary):
- F is loaded from P, or 0x0000 if I_MUTE=1 in that cycle;
- fresh is cleared.
REQ-025 O_SAMPLE_REQ SHALL be 1 exactly during pos=0.
REQ-026 O_UNDERRUN SHALL be 1 during pos=0 iff fresh was 0 at the preceding boundary; the stale P value is still transmitted.
REQ-027 Simultaneous I_SAMPLE_EN and boundary:
- the old P goes to F;
- the new value lands in P;
- set-fresh wins over clear.
REQ-028 Multiple strobes within one frame: the last strobe wins, with no error indication.
REQ-029 I_MUTE SHALL be sampled only at the boundary; mid-frame changes SHALL NOT alter the frame in flight.

Reset
REQ-030 While W_RESETn=0, all of the following SHALL be 0: pos, P, F, fresh, O_MCLK, O_BCLK, O_LRCK, O_SDATA, O_SAMPLE_REQ, O_UNDERRUN.
REQ-031 After release, counting SHALL start at pos=0, and the first frame SHALL transmit 0x0000 without asserting O_UNDERRUN.
REQ-032 A reset asserted mid-frame SHALL abort the frame immediately; the serial outputs SHALL be low the same cycle.

Verification
REQ-033 Strobe 0x8001 at pos=100 -> next frame: O_SDATA 1,0×14,1 on slots 0..15 and again on slots 32..47; no underrun; O_SAMPLE_REQ once per 512 clocks.
REQ-034 Free-run -> O_BCLK period 8 clocks at 50% duty; O_MCLK period 2; O_LRCK period 512 with falls at pos=504 and rises at pos=248; O_SDATA stable across every O_BCLK rising edge.
REQ-035 Strobe 0x1234 once, then none for 3 frames -> 0x1234 repeats in all 3 frames; O_UNDERRUN pulses at pos=0 of frames 2 and 3 only.
REQ-036 I_MUTE=1 at boundary with P=0x7FFF -> that frame all zeros; I_MUTE raised at pos=20 -> current frame unaffected.
REQ-037 Strobe 0xAAAA exactly at pos=511 with P=0x5555 -> 0x5555 sent now, 0xAAAA next frame, no underrun.
REQ-038 Reset at pos=300 -> outputs 0 asynchronously; after release the first O_SAMPLE_REQ comes 1 clock later and that frame transmits zero data.
